// File: rtl/i_cacheline_adaptor_pkg.sv
// Shared types and sizes for the instruction-side cacheline adaptor.
package i_cacheline_adaptor_pkg;

  localparam int ICLA_BEATS  = 4;
  localparam int ICLA_BEAT_W = 64;
  localparam int ICLA_LINE_W = ICLA_BEATS * ICLA_BEAT_W;
  localparam int ICLA_TAG_W  = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } icla_state_t;

endpackage

// File: rtl/i_cacheline_adaptor_if.sv
// Cache-side and memory-side signals of the adaptor, bundled in one interface.
interface i_cacheline_adaptor_if;
  import i_cacheline_adaptor_pkg::*;

  logic                   read_i;
  logic [31:0]            address_i;
  logic                   flush_i;
  logic [ICLA_LINE_W-1:0] line_o;
  logic                   resp_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic [ICLA_BEAT_W-1:0] burst_i;
  logic                   resp_i;

  modport slave (
    input  read_i, address_i, flush_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o
  );

  modport master (
    output read_i, address_i, flush_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o
  );
endinterface

// File: rtl/i_cacheline_adaptor_register.sv
// Generic load-enabled register with synchronous active-low reset.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst)        r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/i_cacheline_adaptor.sv
// Instruction cacheline adaptor: one 4x64-bit burst per line request.
// Optional one-entry line buffer enabled by defining ICLA_LINE_BUFFER_EN.
module i_cacheline_adaptor
  import i_cacheline_adaptor_pkg::*;
#(
  parameter int BEATS = ICLA_BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  i_cacheline_adaptor_if.slave bus
);
  icla_state_t            r_state;
  logic [1:0]             r_beat;
  logic [ICLA_LINE_W-1:0] r_line;
  logic                   r_resp;
  logic                   r_read;
  logic [ICLA_TAG_W-1:0]  w_addr_latched;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_last_beat;
  logic                   w_unused;

  assign w_accept    = (r_state == IDLE) && bus.read_i;
  assign w_last_beat = bus.resp_i && (r_beat == 2'(BEATS - 1));
  assign w_unused    = &{1'b0, bus.address_i[4:0], bus.flush_i};

  register #(.WIDTH(ICLA_TAG_W)) u_addr_latch (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_d    (bus.address_i[31:5]),
    .o_q    (w_addr_latched)
  );

`ifdef ICLA_LINE_BUFFER_EN
  logic                  r_valid;
  logic [ICLA_TAG_W-1:0] r_tag;

  // A flush in the same cycle as a would-be hit forces a fresh burst.
  assign w_hit = r_valid && (r_tag == bus.address_i[31:5]) && !bus.flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else begin
      if ((r_state == BURST) && w_last_beat) begin
        r_valid <= 1'b1;
        r_tag   <= w_addr_latched;
      end
      if (bus.flush_i) r_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= 2'd0;
      r_read  <= 1'b0;
      r_resp  <= 1'b0;
      r_line  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          if (bus.read_i) begin
            r_beat <= 2'd0;
            if (w_hit) begin
              r_state <= DONE;
              r_resp  <= 1'b1;
            end else begin
              r_state <= BURST;
              r_read  <= 1'b1;
            end
          end
        end
        BURST: begin
          // Beats land in place; line_o is only meaningful once resp_o pulses.
          if (bus.resp_i) begin
            r_line[{r_beat, 6'b0} +: ICLA_BEAT_W] <= bus.burst_i;
            r_beat <= r_beat + 2'd1;
            if (w_last_beat) begin
              r_state <= DONE;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.read_o    = r_read;
  assign bus.resp_o    = r_resp;
  assign bus.line_o    = r_line;
  assign bus.address_o = {w_addr_latched, 5'b0};
endmodule

// File: tb/tb_i_cacheline_adaptor.sv
// Self-checking bench for i_cacheline_adaptor: directed table, corner sequences, random traffic.
module tb_i_cacheline_adaptor;
  import i_cacheline_adaptor_pkg::*;

`ifdef ICLA_LINE_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  i_cacheline_adaptor_if bus_if();

  i_cacheline_adaptor #(.BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int txn_id   = 0;

  logic [255:0] exp_line = '0;
  logic         m_valid  = 1'b0;
  logic [26:0]  m_tag    = '0;

  typedef struct {
    logic [31:0] addr;
    logic        flush;
    logic        exp_hit;
    logic [15:0] mask;
    int          exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycle(input logic stray, input logic flush);
    bus_if.read_i  = 1'b0;
    bus_if.resp_i  = stray;
    bus_if.burst_i = {$urandom, $urandom};
    bus_if.flush_i = flush;
    step();
    if (flush) m_valid = 1'b0;
    bus_if.resp_i  = 1'b0;
    bus_if.flush_i = 1'b0;
    chk("idle_resp", bus_if.resp_o, 1'b0);
    chk("idle_read", bus_if.read_o, 1'b0);
    chk("idle_line", bus_if.line_o, exp_line);
  endtask

  // One cache request; beats follow mask (bit n = cycle n+1) or random gaps.
  task automatic txn(input logic [31:0] addr, input logic flush, input logic exp_hit,
                     input logic [15:0] mask, input bit rand_gaps, input int exp_resp);
    int          cyc;
    int          beats;
    logic [63:0] beat;
    logic        send;
    txn_id++;
    bus_if.read_i    = 1'b1;
    bus_if.address_i = addr;
    bus_if.flush_i   = flush;
    bus_if.resp_i    = 1'b0;
    if (flush) m_valid = 1'b0;
    step();
    bus_if.flush_i = 1'b0;
    if (exp_hit) begin
      chk("hit_resp", bus_if.resp_o, 1'b1);
      chk("hit_read", bus_if.read_o, 1'b0);
      chk("hit_line", bus_if.line_o, exp_line);
      step();
      bus_if.read_i = 1'b0;
      chk("hit_resp_drop", bus_if.resp_o, 1'b0);
      chk("hit_read_idle", bus_if.read_o, 1'b0);
      $display("txn %0d addr=%h hit line=%h", txn_id, addr, bus_if.line_o);
    end else begin
      chk("miss_addr", bus_if.address_o, {addr[31:5], 5'b0});
      cyc   = 1;
      beats = 0;
      while (beats < 4 && cyc <= 64) begin
        chk("early_resp", bus_if.resp_o, 1'b0);
        chk("burst_read", bus_if.read_o, 1'b1);
        if (rand_gaps) send = (cyc > 20) || ($urandom_range(0, 1) == 1);
        else           send = (cyc <= 16) && mask[cyc-1];
        if (send) begin
          beat = rand_gaps ? {$urandom, $urandom} : {16'hC0DE, 16'(txn_id), 32'(beats)};
          bus_if.burst_i = beat;
          bus_if.resp_i  = 1'b1;
          exp_line[beats*64 +: 64] = beat;
          beats++;
        end else begin
          bus_if.burst_i = {$urandom, $urandom};
          bus_if.resp_i  = 1'b0;
        end
        step();
        bus_if.resp_i = 1'b0;
        cyc++;
      end
      if (beats < 4) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=%0d beats required=4", beats);
      end
      chk("done_resp", bus_if.resp_o, 1'b1);
      chk("done_read", bus_if.read_o, 1'b0);
      chk("done_line", bus_if.line_o, exp_line);
      if (exp_resp > 0) chk("resp_cycle", 256'(cyc), 256'(exp_resp));
      step();
      bus_if.read_i = 1'b0;
      chk("resp_pulse", bus_if.resp_o, 1'b0);
      m_valid = 1'b1;
      m_tag   = addr[31:5];
      $display("txn %0d addr=%h miss resp_cycle=%0d line=%h", txn_id, addr, cyc, bus_if.line_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pool [4];
    logic [31:0] a;
    logic        fl;

    vecs[0] = '{32'h0000_1234, 1'b0, 1'b0,   16'h000F, 5};
    vecs[1] = '{32'h0000_1234, 1'b0, BUF_EN, 16'h000F, 5};
    vecs[2] = '{32'h0000_1234, 1'b1, 1'b0,   16'h0065, 8};
    vecs[3] = '{32'hDEAD_BEEF, 1'b0, 1'b0,   16'h00F0, 9};
    vecs[4] = '{32'hDEAD_BEE0, 1'b0, BUF_EN, 16'h000F, 5};
    vecs[5] = '{32'h0000_1234, 1'b0, 1'b0,   16'h0F00, 13};

    bus_if.read_i    = 1'b0;
    bus_if.address_i = '0;
    bus_if.flush_i   = 1'b0;
    bus_if.burst_i   = '0;
    bus_if.resp_i    = 1'b0;

    rst = 1'b0;
    repeat (3) step();
    chk("rst_read", bus_if.read_o, 1'b0);
    chk("rst_resp", bus_if.resp_o, 1'b0);
    chk("rst_addr", bus_if.address_o, 32'h0);
    chk("rst_line", bus_if.line_o, 256'h0);
    rst = 1'b1;
    step();

    foreach (vecs[i])
      txn(vecs[i].addr, vecs[i].flush, vecs[i].exp_hit, vecs[i].mask, 1'b0, vecs[i].exp_resp);

    // Stray beats while idle must not start anything or touch the line.
    for (int i = 0; i < 3; i++) idle_cycle(1'b1, 1'b0);

    // Reset two beats into a burst, then stray beat in IDLE, then a clean miss.
    bus_if.read_i    = 1'b1;
    bus_if.address_i = 32'h0000_4000;
    step();
    chk("mid_read", bus_if.read_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus_if.resp_i  = 1'b1;
      bus_if.burst_i = {$urandom, $urandom};
      step();
    end
    rst            = 1'b0;
    bus_if.read_i  = 1'b0;
    bus_if.resp_i  = 1'b1;
    step();
    rst = 1'b1;
    chk("mid_rst_read", bus_if.read_o, 1'b0);
    chk("mid_rst_resp", bus_if.resp_o, 1'b0);
    chk("mid_rst_addr", bus_if.address_o, 32'h0);
    chk("mid_rst_line", bus_if.line_o, 256'h0);
    exp_line = '0;
    m_valid  = 1'b0;
    idle_cycle(1'b1, 1'b0);
    txn(32'hDEAD_BEE4, 1'b0, 1'b0, 16'h000F, 1'b0, 5);

    pool[0] = 32'h0000_1220;
    pool[1] = 32'h8000_0040;
    pool[2] = 32'h0001_FFE0;
    pool[3] = 32'h4000_0000;
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      a  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
      fl = 1'($urandom_range(0, 5) == 0);
      txn(a, fl, BUF_EN && m_valid && (m_tag == a[31:5]) && !fl, 16'h0, 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
